// File: rtl/vga_pkg.sv
// Shared constants for the VGA banner generator: default 640x480@60 timing,
// character codes, the message table and the 8x8 glyph bitmaps.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam logic [1:0] MSG_LOSE  = 2'd0;
  localparam logic [1:0] MSG_WIN   = 2'd1;
  localparam logic [1:0] MSG_PAUSE = 2'd2;
  localparam logic [1:0] MSG_BLANK = 2'd3;

  typedef enum logic [3:0] {
    CH_SPACE = 4'd0,
    CH_Y     = 4'd1,
    CH_O     = 4'd2,
    CH_U     = 4'd3,
    CH_L     = 4'd4,
    CH_S     = 4'd5,
    CH_E     = 4'd6,
    CH_W     = 4'd7,
    CH_I     = 4'd8,
    CH_N     = 4'd9,
    CH_P     = 4'd10,
    CH_A     = 4'd11,
    CH_D     = 4'd12
  } char_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Character 0 of every message sits in the most significant nibble.
  function automatic char_t msg_char(input logic [1:0] msg, input logic [2:0] idx);
    logic [31:0] text;
    case (msg)
      MSG_LOSE:  text = {CH_Y, CH_O, CH_U, CH_SPACE, CH_L, CH_O, CH_S, CH_E};
      MSG_WIN:   text = {CH_Y, CH_O, CH_U, CH_SPACE, CH_W, CH_I, CH_N, CH_SPACE};
      MSG_PAUSE: text = {CH_P, CH_A, CH_U, CH_S, CH_E, CH_D, CH_SPACE, CH_SPACE};
      default:   text = '0;
    endcase
    return char_t'(text[{~idx, 2'b00} +: 4]);
  endfunction

  // Bitmaps are row 0 (top) in the most significant byte; bit 7 is the leftmost column.
  function automatic logic [7:0] glyph_row(input char_t code, input logic [2:0] row);
    logic [63:0] bmp;
    case (code)
      CH_Y:    bmp = 64'h4242_2418_1818_1800;
      CH_O:    bmp = 64'h3C42_4242_4242_3C00;
      CH_U:    bmp = 64'h4242_4242_4242_3C00;
      CH_L:    bmp = 64'h4040_4040_4040_7E00;
      CH_S:    bmp = 64'h3C40_403C_0202_3C00;
      CH_E:    bmp = 64'h7E40_407C_4040_7E00;
      CH_W:    bmp = 64'h4242_4242_5A66_4200;
      CH_I:    bmp = 64'h3C18_1818_1818_3C00;
      CH_N:    bmp = 64'h4262_524A_4642_4200;
      CH_P:    bmp = 64'h7C42_427C_4040_4000;
      CH_A:    bmp = 64'h1824_4242_7E42_4200;
      CH_D:    bmp = 64'h7844_4242_4244_7800;
      default: bmp = '0;
    endcase
    return bmp[{~row, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// Glyph bitmap ROM with a registered output; advances only on pixel ticks.
module vga_glyph_rom
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       pix_en,
  input  logic [3:0] code,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bits <= '0;
    end else if (pix_en) begin
      bits <= glyph_row(char_t'(code), row);
    end
  end

endmodule

// File: rtl/vga_banner_gen.sv
// VGA timing generator with a scaled 8-character text banner and optional border.
// Counters -> geometry/glyph fetch -> colour mux; sync and vidon ride the same pipe.
module vga_banner_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int SYNC_ACT  = 0,
  parameter int SCALE_SH  = 2,
  parameter int TXT_X     = 192,
  parameter int TXT_Y     = 224,
  parameter int BORDER_W  = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        pix_en,
  input  logic [1:0]  msg_sel,
  input  logic [11:0] fg_rgb,
  input  logic [11:0] bg_rgb,
  input  logic        border_en,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        vidon,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int CW      = max3(10, $clog2(H_TOTAL), $clog2(V_TOTAL));

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BW       = CW'(BORDER_W);
  localparam logic [CW-1:0] H_BR     = CW'(H_VISIBLE - BORDER_W);
  localparam logic [CW-1:0] V_BR     = CW'(V_VISIBLE - BORDER_W);

  localparam logic signed [CW:0] TXT_XS = (CW+1)'(TXT_X);
  localparam logic signed [CW:0] TXT_YS = (CW+1)'(TXT_Y);
  localparam logic signed [CW:0] TXT_W  = (CW+1)'(64 << SCALE_SH);
  localparam logic signed [CW:0] TXT_H  = (CW+1)'(8 << SCALE_SH);

  localparam logic SYNC_ON = 1'(SYNC_ACT);

  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_wrap;

  logic [1:0]    msg_l;
  logic [11:0]   fg_l;
  logic [11:0]   bg_l;
  logic          border_l;

  logic signed [CW:0] dx_p0;
  logic signed [CW:0] dy_p0;
  logic          in_txt_p0;
  logic          vld_p0;
  logic          border_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic [3:0]    code_p0;

  logic [7:0]    bits_p1;
  logic [2:0]    col_p1;
  logic          in_txt_p1;
  logic          vld_p1;
  logic          border_p1;
  logic          hs_p1;
  logic          vs_p1;
  logic          txt_bit_p1;

  logic [11:0]   rgb_p2;
  logic          vld_p2;
  logic          hs_p2;
  logic          vs_p2;

  // ---- stage 0: raster counters and frame-coherent control latch ----
  assign h_wrap     = (hcount == H_LAST);
  assign v_wrap     = (vcount == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      // A pulse, not state: drops after one clk even if the next tick is far off.
      frame_start <= pix_en && frame_wrap;
      if (pix_en) begin
        hcount <= h_wrap ? '0 : hcount + 1'b1;
        if (h_wrap) begin
          vcount <= v_wrap ? '0 : vcount + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      msg_l    <= MSG_BLANK;
      fg_l     <= '0;
      bg_l     <= '0;
      border_l <= 1'b0;
    end else if (pix_en && frame_wrap) begin
      msg_l    <= msg_sel;
      fg_l     <= fg_rgb;
      bg_l     <= bg_rgb;
      border_l <= border_en;
    end
  end

  assign dx_p0 = $signed({1'b0, hcount}) - TXT_XS;
  assign dy_p0 = $signed({1'b0, vcount}) - TXT_YS;

  // Sign bit set means left of / above the banner, so clipping needs no extra test.
  assign in_txt_p0 = !dx_p0[CW] && (dx_p0 < TXT_W) && !dy_p0[CW] && (dy_p0 < TXT_H);
  assign vld_p0    = (hcount < H_VIS) && (vcount < V_VIS);
  assign border_p0 = border_l && ((hcount < BW) || (hcount >= H_BR) ||
                                  (vcount < BW) || (vcount >= V_BR));
  assign hs_p0     = ((hcount >= HS_START) && (hcount < HS_END)) ? SYNC_ON : ~SYNC_ON;
  assign vs_p0     = ((vcount >= VS_START) && (vcount < VS_END)) ? SYNC_ON : ~SYNC_ON;
  assign code_p0   = msg_char(msg_l, dx_p0[SCALE_SH+3 +: 3]);

  // ---- stage 1: glyph row fetch and geometry flags ----
  vga_glyph_rom u_rom (
    .clk    (clk),
    .clr_n  (clr_n),
    .pix_en (pix_en),
    .code   (code_p0),
    .row    (dy_p0[SCALE_SH +: 3]),
    .bits   (bits_p1)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      col_p1    <= '0;
      in_txt_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      hs_p1     <= ~SYNC_ON;
      vs_p1     <= ~SYNC_ON;
    end else if (pix_en) begin
      col_p1    <= dx_p0[SCALE_SH +: 3];
      in_txt_p1 <= in_txt_p0;
      vld_p1    <= vld_p0;
      border_p1 <= border_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
    end
  end

  // ---- stage 2: colour mux ----
  assign txt_bit_p1 = in_txt_p1 && bits_p1[~col_p1];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= ~SYNC_ON;
      vs_p2  <= ~SYNC_ON;
    end else if (pix_en) begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      if (!vld_p1) begin
        rgb_p2 <= '0;
      end else if (txt_bit_p1 || border_p1) begin
        rgb_p2 <= fg_l;
      end else begin
        rgb_p2 <= bg_l;
      end
    end
  end

  assign hsync = hs_p2;
  assign vsync = vs_p2;
  assign vidon = vld_p2;
  assign r     = rgb_p2[11:8];
  assign g     = rgb_p2[7:4];
  assign b     = rgb_p2[3:0];

endmodule

// File: tb/tb_vga_banner_gen.sv
// Directed bench for vga_banner_gen in a reduced 128x64 mode (144x72 total, 2x glyphs).
module tb_vga_banner_gen;

  localparam int HT = 144;
  localparam int VT = 72;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [1:0]  msg_sel = 2'd0;
  logic [11:0] fg_rgb = 12'h000;
  logic [11:0] bg_rgb = 12'h000;
  logic        border_en = 1'b0;
  logic        hsync, vsync, vidon, frame_start;
  logic [3:0]  r, g, b;

  int   checks = 0;
  int   errors = 0;
  int   ticks = 0;
  logic last_en = 1'b0;

  always #5 clk = ~clk;

  vga_banner_gen #(
    .H_VISIBLE (128), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VISIBLE (64),  .V_FP (2), .V_SYNC (2), .V_BP (4),
    .SYNC_ACT (0), .SCALE_SH (1), .TXT_X (16), .TXT_Y (16), .BORDER_W (4)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .pix_en      (pix_en),
    .msg_sel     (msg_sel),
    .fg_rgb      (fg_rgb),
    .bg_rgb      (bg_rgb),
    .border_en   (border_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .r           (r),
    .g           (g),
    .b           (b),
    .vidon       (vidon),
    .frame_start (frame_start)
  );

  // One clock; ticks counts pixel ticks since the last reset release.
  task automatic step();
    @(posedge clk);
    last_en = pix_en;
    if (pix_en) ticks++;
    @(negedge clk);
  endtask

  // Output after tick n shows raster pixel n-2 (two-tick latency).
  task automatic goto(input int frame, input int x, input int y);
    int target;
    target = frame * FT + y * HT + x + 2;
    while (ticks < target) step();
  endtask

  task automatic test_reset();
    int n;
    clr_n = 1'b0; pix_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({hsync, vsync, vidon, frame_start, r, g, b} !== {4'b1100, 12'h000}) begin
      errors++;
      $display("FAIL reset_hold: hs/vs/vid/fs/rgb=%b%b%b%b/%h expected 1100/000",
               hsync, vsync, vidon, frame_start, {r, g, b});
    end
    clr_n = 1'b1; ticks = 0;
    while (ticks < 50) step();
    checks++;
    if (vidon !== 1'b1) begin
      errors++; $display("FAIL vidon_line0: vidon=%b expected 1", vidon);
    end
    while (ticks < 136) step();
    checks++;
    if (hsync !== 1'b0) begin
      errors++; $display("FAIL hsync_pre_reset: hsync=%b expected 0", hsync);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, vidon, frame_start, r, g, b} !== {4'b1100, 12'h000}) begin
      errors++;
      $display("FAIL async_reset: hs/vs/vid/fs/rgb=%b%b%b%b/%h expected 1100/000",
               hsync, vsync, vidon, frame_start, {r, g, b});
    end
    @(negedge clk);
    clr_n = 1'b1; ticks = 0; n = 0;
    while (hsync !== 1'b0 && n < 1000) begin step(); n++; end
    checks++;
    if (ticks !== 134) begin
      errors++; $display("FAIL first_hsync_fall: tick=%0d expected 134", ticks);
    end
  endtask

  task automatic test_timing();
    int   hf1 = -1, hf2 = -1, hr = -1, vf = -1, vr = -1;
    int   fs1 = -1, fs2 = -1, fs_cnt = 0, fs_wide = 0;
    logic ph, pv, pf;
    msg_sel = 2'd0; fg_rgb = 12'hFFF; bg_rgb = 12'h000; border_en = 1'b0;
    ph = hsync; pv = vsync; pf = frame_start;
    while (ticks < 2 * FT + 10) begin
      step();
      if (ph && !hsync) begin
        if (hf1 < 0) hf1 = ticks; else if (hf2 < 0) hf2 = ticks;
      end
      if (!ph && hsync && hf1 >= 0 && hr < 0) hr = ticks;
      if (pv && !vsync && vf < 0) vf = ticks;
      if (!pv && vsync && vf >= 0 && vr < 0) vr = ticks;
      if (frame_start) begin
        if (pf) fs_wide++;
        else begin
          fs_cnt++;
          if (fs1 < 0) fs1 = ticks; else if (fs2 < 0) fs2 = ticks;
        end
      end
      ph = hsync; pv = vsync; pf = frame_start;
    end
    checks++;
    if (hf2 - hf1 !== 144) begin errors++; $display("FAIL line_period: %0d expected 144", hf2 - hf1); end
    checks++;
    if (hr - hf1 !== 8) begin errors++; $display("FAIL hsync_width: %0d expected 8", hr - hf1); end
    checks++;
    if (vf !== 9506) begin errors++; $display("FAIL vsync_fall: tick %0d expected 9506", vf); end
    checks++;
    if (vr - vf !== 288) begin errors++; $display("FAIL vsync_width: %0d expected 288", vr - vf); end
    checks++;
    if (fs1 !== FT) begin errors++; $display("FAIL frame_start_tick: %0d expected %0d", fs1, FT); end
    checks++;
    if (fs2 - fs1 !== FT) begin errors++; $display("FAIL frame_period: %0d expected %0d", fs2 - fs1, FT); end
    checks++;
    if (fs_cnt !== 2) begin errors++; $display("FAIL frame_start_count: %0d expected 2", fs_cnt); end
    checks++;
    if (fs_wide !== 0) begin errors++; $display("FAIL frame_start_width: extra %0d clks expected 0", fs_wide); end
  endtask

  task automatic test_glyph();
    int          px [9] = '{16, 18, 80, 82, 92, 70, 130, 86, 82};
    int          py [9] = '{16, 16, 16, 16, 16, 18, 20, 28, 30};
    logic [12:0] ex [9] = '{13'h1000, 13'h1FFF, 13'h1000, 13'h1FFF, 13'h1000,
                            13'h1000, 13'h0000, 13'h1FFF, 13'h1000};
    for (int i = 0; i < 9; i++) begin
      goto(2, px[i], py[i]);
      checks++;
      if ({vidon, r, g, b} !== ex[i]) begin
        errors++;
        $display("FAIL glyph(%0d,%0d): vid/rgb=%h expected %h", px[i], py[i], {vidon, r, g, b}, ex[i]);
      end
    end
  endtask

  task automatic test_msg_change();
    int          pf [8] = '{3, 3, 4, 4, 4, 4, 4, 4};
    int          px [8] = '{82, 92, 80, 82, 92, 114, 82, 92};
    int          py [8] = '{26, 26, 16, 16, 16, 16, 26, 26};
    logic [11:0] ex [8] = '{12'hFFF, 12'h000, 12'h000, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
    goto(3, 0, 20);
    msg_sel = 2'd1; fg_rgb = 12'h0F0;
    for (int i = 0; i < 8; i++) begin
      goto(pf[i], px[i], py[i]);
      checks++;
      if ({r, g, b} !== ex[i]) begin
        errors++;
        $display("FAIL msg_frame%0d(%0d,%0d): rgb=%h expected %h", pf[i], px[i], py[i], {r, g, b}, ex[i]);
      end
    end
  endtask

  task automatic test_border();
    int          px [10] = '{0, 4, 3, 123, 124, 130, 10, 10, 127, 10};
    int          py [10] = '{0, 4, 10, 10, 10, 10, 59, 60, 63, 65};
    logic [12:0] ex [10] = '{13'h1F00, 13'h100F, 13'h1F00, 13'h100F, 13'h1F00,
                             13'h0000, 13'h100F, 13'h1F00, 13'h1F00, 13'h0000};
    goto(4, 0, 40);
    msg_sel = 2'd3; border_en = 1'b1; fg_rgb = 12'hF00; bg_rgb = 12'h00F;
    for (int i = 0; i < 10; i++) begin
      goto(5, px[i], py[i]);
      checks++;
      if ({vidon, r, g, b} !== ex[i]) begin
        errors++;
        $display("FAIL border(%0d,%0d): vid/rgb=%h expected %h", px[i], py[i], {vidon, r, g, b}, ex[i]);
      end
    end
  endtask

  task automatic test_pix_en();
    int          f1 = -1, f2 = -1, rise = -1, viol = 0;
    logic        ph;
    logic [14:0] prev;
    ph = hsync;
    for (int c = 0; c < 2400; c++) begin
      pix_en = (c % 4 == 0);
      prev = {hsync, vsync, vidon, r, g, b};
      step();
      if (!last_en && {hsync, vsync, vidon, r, g, b} !== prev) viol++;
      if (ph && !hsync) begin
        if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
      end
      if (!ph && hsync && f1 >= 0 && rise < 0) rise = c;
      ph = hsync;
    end
    pix_en = 1'b1;
    checks++;
    if (f2 - f1 !== 576) begin errors++; $display("FAIL slow_line_period: %0d clks expected 576", f2 - f1); end
    checks++;
    if (rise - f1 !== 32) begin errors++; $display("FAIL slow_hsync_width: %0d clks expected 32", rise - f1); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL hold_between_ticks: %0d changes expected 0", viol); end
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_timing();
    test_glyph();
    test_msg_change();
    test_border();
    test_pix_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
